// File: rtl/window_pan.sv
// window_pan: pans an OUT_WIDTH x OUT_HEIGHT crop over an RGB888 stream, emits RGB565 with frame markers.
// Optional 2:1 decimating window when WIN_PAN_DECIM_EN is defined.
module window_pan #(
  parameter int IN_WIDTH   = 1936,
  parameter int IN_HEIGHT  = 1088,
  parameter int OUT_WIDTH  = 640,
  parameter int OUT_HEIGHT = 480,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_en,
  input  logic             in_sof,
  input  logic [23:0]      in_data,
  input  logic [CNT_W-1:0] cfg_x,
  input  logic [CNT_W-1:0] cfg_y,
  input  logic             err_clr,
  output logic             out_en,
  output logic [15:0]      out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             frame_err,
  output logic             err_sticky,
  output logic             busy
);
`ifdef WIN_PAN_DECIM_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int SPAN_X = OUT_WIDTH * STEP;
  localparam int SPAN_Y = OUT_HEIGHT * STEP;
  localparam logic [CNT_W-1:0] MAX_X  = CNT_W'(IN_WIDTH - SPAN_X);
  localparam logic [CNT_W-1:0] MAX_Y  = CNT_W'(IN_HEIGHT - SPAN_Y);
  localparam logic [CNT_W-1:0] LAST_X = CNT_W'(IN_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(IN_HEIGHT - 1);
  localparam logic [CNT_W-1:0] SPX    = CNT_W'(SPAN_X);
  localparam logic [CNT_W-1:0] SPY    = CNT_W'(SPAN_Y);
  localparam logic [CNT_W-1:0] EOL_X  = CNT_W'(SPAN_X - STEP);
  localparam logic [CNT_W-1:0] EOF_Y  = CNT_W'(SPAN_Y - STEP);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d, ox_q, ox_d, oy_q, oy_d;
  logic [CNT_W-1:0] px, py, dx, dy;
  logic             long_q, long_d;
  logic             sof, take, hit, last_col, last, err;
  logic             en_q, en_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic             ferr_q, ferr_d, sticky_q, sticky_d;
  logic [15:0]      data_q, data_d;
  logic             unused_bits;

  assign unused_bits = ^{in_data[18:16], in_data[9:8], in_data[2:0]};

  // Pixel position, origin capture, window hit, frame tracking and error detection.
  always_comb begin
    sof      = in_en & in_sof;
    take     = in_en & (in_sof | (state_q == ACTIVE));
    px       = sof ? '0 : h_q;
    py       = sof ? '0 : v_q;
    ox_d     = sof ? ((cfg_x > MAX_X) ? MAX_X : cfg_x) : ox_q;
    oy_d     = sof ? ((cfg_y > MAX_Y) ? MAX_Y : cfg_y) : oy_q;
    dx       = px - ox_d;
    dy       = py - oy_d;
`ifdef WIN_PAN_DECIM_EN
    hit      = take && px >= ox_d && dx < SPX && py >= oy_d && dy < SPY && !dx[0] && !dy[0];
`else
    hit      = take && px >= ox_d && dx < SPX && py >= oy_d && dy < SPY;
`endif
    last_col = px == LAST_X;
    last     = last_col && py == LAST_Y;
    h_d      = take ? (last_col ? '0 : px + 1'b1) : h_q;
    v_d      = take ? (last_col ? (last ? '0 : py + 1'b1) : py) : v_q;
    state_d  = take ? (last ? DONE : ACTIVE) : state_q;
    long_d   = sof ? 1'b0 : ((state_q == DONE && in_en) ? 1'b1 : long_q);
    err      = (sof && state_q == ACTIVE) || (in_en && !in_sof && state_q == DONE && !long_q);
    en_d     = hit;
    data_d   = hit ? {in_data[23:19], in_data[15:10], in_data[7:3]} : data_q;
    sof_d    = hit && dx == '0 && dy == '0;
    eol_d    = hit && dx == EOL_X;
    eof_d    = hit && dx == EOL_X && dy == EOF_Y;
    ferr_d   = err;
    sticky_d = err | (sticky_q & ~err_clr);
  end

  // State, counters, shadow origin and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      h_q      <= '0;
      v_q      <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      long_q   <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= '0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      ferr_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      long_q   <= long_d;
      en_q     <= en_d;
      data_q   <= data_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
      ferr_q   <= ferr_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_en     = en_q;
  assign out_data   = data_q;
  assign out_sof    = sof_q;
  assign out_eol    = eol_q;
  assign out_eof    = eof_q;
  assign frame_err  = ferr_q;
  assign err_sticky = sticky_q;
  assign busy       = state_q == ACTIVE;
endmodule

// File: tb/tb_window_pan.sv
// tb_window_pan: directed checks of window_pan on a 16x8 frame with a 4x2 window.
module tb_window_pan;
  logic        clk = 0, rstn = 0, in_en = 0, in_sof = 0, err_clr = 0;
  logic [23:0] in_data = 24'hFF8040;
  logic [4:0]  cfg_x = 5'd3, cfg_y = 5'd2;
  logic        out_en, out_sof, out_eol, out_eof, frame_err, err_sticky, busy;
  logic [15:0] out_data;

  window_pan #(.IN_WIDTH(16), .IN_HEIGHT(8), .OUT_WIDTH(4), .OUT_HEIGHT(2), .CNT_W(5)) dut (
    .clk(clk), .rstn(rstn), .in_en(in_en), .in_sof(in_sof), .in_data(in_data),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .err_clr(err_clr), .out_en(out_en), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .frame_err(frame_err),
    .err_sticky(err_sticky), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int n_en, n_sof, n_eol, n_eof, n_err, first_pos, sof_pos, eof_pos, eol0, eol1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives n contiguous pixels; outputs sampled 1ns after the edge that takes each pixel,
  // so an event logged at index i came exactly one cycle after input pixel i.
  task automatic run(input int n, input bit sof_first, input int chg_at, input logic [4:0] chg_x);
    n_en = 0; n_sof = 0; n_eol = 0; n_eof = 0; n_err = 0;
    first_pos = -1; sof_pos = -1; eof_pos = -1; eol0 = -1; eol1 = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_en = 1; in_sof = sof_first && i == 0;
      if (i == chg_at) cfg_x = chg_x;
      @(posedge clk); #1;
      in_en = 0; in_sof = 0;
      if (out_en) begin n_en++; if (first_pos < 0) first_pos = i; end
      if (out_sof) begin n_sof++; sof_pos = i; end
      if (out_eol) begin if (n_eol == 0) eol0 = i; else eol1 = i; n_eol++; end
      if (out_eof) begin n_eof++; eof_pos = i; end
      if (frame_err) n_err++;
    end
  endtask

  initial begin
    #1;
    chk("reset_outputs", {out_en, out_sof, out_eol, out_eof, frame_err, err_sticky, busy, out_data}, 0);
    @(negedge clk); rstn = 1;
`ifdef WIN_PAN_DECIM_EN
    cfg_x = 5'd2; cfg_y = 5'd0;
    run(128, 1, -1, 0);
    chk("dec_count", n_en, 8);
    chk("dec_first", first_pos, 2);
    chk("dec_sof", sof_pos, 2);
    chk("dec_eol_n", n_eol, 2);
    chk("dec_eol0", eol0, 8);
    chk("dec_eol1", eol1, 40);
    chk("dec_eof_n", n_eof, 1);
    chk("dec_eof", eof_pos, 40);
    cfg_x = 5'd20; cfg_y = 5'd7;
    run(128, 1, -1, 0);
    chk("dec_clamp_first", first_pos, 72);
    chk("dec_clamp_eol0", eol0, 78);
    chk("dec_clamp_eof", eof_pos, 110);
    chk("dec_clamp_count", n_en, 8);
`else
    run(5, 0, -1, 0);
    chk("idle_drop_en", n_en, 0);
    chk("idle_drop_err", n_err, 0);
    chk("idle_busy", busy, 0);
    run(128, 1, -1, 0);
    chk("a_count", n_en, 8);
    chk("a_first", first_pos, 35);
    chk("a_sof_n", n_sof, 1);
    chk("a_sof", sof_pos, 35);
    chk("a_eol_n", n_eol, 2);
    chk("a_eol0", eol0, 38);
    chk("a_eol1", eol1, 54);
    chk("a_eof_n", n_eof, 1);
    chk("a_eof", eof_pos, 54);
    chk("a_err", n_err, 0);
    chk("a_data_hold", out_data, 16'hFC08);
    chk("a_busy_done", busy, 0);
    in_data = 24'h123456;
    run(128, 1, -1, 0);
    chk("b_count", n_en, 8);
    chk("b_eof", eof_pos, 54);
    chk("b_data", out_data, 16'h11AA);
    cfg_x = 5'd20; cfg_y = 5'd7;
    run(128, 1, -1, 0);
    chk("clamp_count", n_en, 8);
    chk("clamp_first", first_pos, 108);
    chk("clamp_eol0", eol0, 111);
    chk("clamp_eof", eof_pos, 127);
    cfg_x = 5'd3; cfg_y = 5'd2;
    run(128, 1, 10, 5'd8);
    chk("mid_first", first_pos, 35);
    chk("mid_eof", eof_pos, 54);
    run(128, 1, -1, 0);
    chk("next_first", first_pos, 40);
    chk("next_eol0", eol0, 43);
    chk("next_eof", eof_pos, 59);
    cfg_x = 5'd3;
    run(50, 1, -1, 0);
    chk("short_count", n_en, 4);
    chk("short_busy", busy, 1);
    run(128, 1, -1, 0);
    chk("short_err", n_err, 1);
    chk("short_no_eof_then_full", n_eof, 1);
    chk("short_restart_count", n_en, 8);
    chk("short_restart_eof", eof_pos, 54);
    chk("sticky_set", err_sticky, 1);
    @(negedge clk); err_clr = 1;
    @(posedge clk); #1; err_clr = 0;
    chk("sticky_clr", err_sticky, 0);
    err_clr = 1;
    run(1, 0, -1, 0);
    err_clr = 0;
    chk("long_err_first", n_err, 1);
    chk("sticky_set_wins", err_sticky, 1);
    run(9, 0, -1, 0);
    chk("long_err_rest", n_err, 0);
    chk("long_no_out", n_en, 0);
    chk("long_busy", busy, 0);
    run(37, 1, -1, 0);
    chk("pre_rst_en", out_en, 1);
    chk("pre_rst_busy", busy, 1);
    #2 rstn = 0;
    #1 chk("async_rst", {out_en, out_sof, out_eol, out_eof, frame_err, err_sticky, busy, out_data}, 0);
    @(negedge clk); rstn = 1;
    run(30, 0, -1, 0);
    chk("post_rst_drop", n_en, 0);
    chk("post_rst_err", n_err, 0);
    chk("post_rst_busy", busy, 0);
    run(128, 1, -1, 0);
    chk("post_rst_frame", n_en, 8);
    chk("post_rst_eof", eof_pos, 54);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
